// File: rtl/ex_mem_wb_stage.sv
// Multi-cycle execute / memory / writeback back end for the RV32 core.
// Takes one ID/EX bundle at a time, runs the ALU, optionally one memory access, then one register write.
//
// state | meaning
// IDLE  | no op in flight, ready for a bundle
// EXEC  | ALU result registered into res_q
// MREQ  | memory request held until granted
// MWAIT | granted load waiting for rvalid
// WB    | one-cycle register-file write, may accept the next bundle
module ex_mem_wb_stage #(
  parameter int D_WIDTH = 32,
  parameter int RF_SIZE = 5,
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_rs1_val,
  input  logic [D_WIDTH-1:0] in_rs2_val,
  input  logic [D_WIDTH-1:0] in_imm,
  input  logic [RF_SIZE-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               in_alu_src_imm,
  input  logic [OP_SIZE-1:0] in_alu_op,
  input  logic               in_mem_we,
  input  logic               in_mem_re,
  input  logic               flush,
  output logic               mem_req,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               wb_we,
  output logic [RF_SIZE-1:0] wb_rd,
  output logic [D_WIDTH-1:0] wb_data,
  output logic               pend_we,
  output logic [RF_SIZE-1:0] pend_rd,
  output logic               busy
);

  localparam int SH_W = $clog2(D_WIDTH);

  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_SUB  = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_AND  = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_OR   = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_SLL  = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] OP_SRL  = OP_SIZE'(6);
  localparam logic [OP_SIZE-1:0] OP_SRA  = OP_SIZE'(7);
  localparam logic [OP_SIZE-1:0] OP_SLT  = OP_SIZE'(8);
  localparam logic [OP_SIZE-1:0] OP_SLTU = OP_SIZE'(9);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MREQ, S_MWAIT, S_WB} state_t;

  state_t               state, state_nxt;
  logic [D_WIDTH-1:0]   rs1_q, rs2_q, imm_q, res_q;
  logic [RF_SIZE-1:0]   rd_q;
  logic [OP_SIZE-1:0]   op_q;
  logic                 reg_write_q, src_imm_q, load_q, store_q, kill_q;
  logic                 accept;
  logic [D_WIDTH-1:0]   alu_b, alu_res;
  logic [SH_W-1:0]      shamt;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (load_q || store_q) state_nxt = S_MREQ;
        else                       state_nxt = S_WB;
      end
      // a grant commits the access even if flush arrives in the same cycle
      S_MREQ: begin
        if (mem_gnt)    state_nxt = store_q ? S_WB : S_MWAIT;
        else if (flush) state_nxt = S_IDLE;
      end
      S_MWAIT: if (mem_rvalid) state_nxt = (kill_q || flush) ? S_IDLE : S_WB;
      S_WB:    state_nxt = accept ? S_EXEC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_b   = src_imm_q ? imm_q : rs2_q;
    shamt   = alu_b[SH_W-1:0];
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = rs1_q + alu_b;
      OP_SUB:  alu_res = rs1_q - alu_b;
      OP_AND:  alu_res = rs1_q & alu_b;
      OP_OR:   alu_res = rs1_q | alu_b;
      OP_XOR:  alu_res = rs1_q ^ alu_b;
      OP_SLL:  alu_res = rs1_q << shamt;
      OP_SRL:  alu_res = rs1_q >> shamt;
      OP_SRA:  alu_res = D_WIDTH'($signed(rs1_q) >>> shamt);
      OP_SLT:  alu_res = D_WIDTH'($signed(rs1_q) < $signed(alu_b));
      OP_SLTU: alu_res = D_WIDTH'(rs1_q < alu_b);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      res_q       <= '0;
      rd_q        <= '0;
      op_q        <= '0;
      reg_write_q <= 1'b0;
      src_imm_q   <= 1'b0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      if (accept) begin
        rs1_q       <= in_rs1_val;
        rs2_q       <= in_rs2_val;
        imm_q       <= in_imm;
        rd_q        <= in_rd;
        op_q        <= in_alu_op;
        reg_write_q <= in_reg_write;
        src_imm_q   <= in_alu_src_imm;
        load_q      <= in_mem_re;
        store_q     <= in_mem_we && !in_mem_re;
        kill_q      <= 1'b0;
      end
      if (state == S_EXEC) res_q <= alu_res;
      if (state == S_MWAIT && mem_rvalid) res_q <= mem_rdata;
      // a flushed load that was already granted must still drain its response
      if ((state == S_MREQ && mem_gnt && flush) || (state == S_MWAIT && flush)) kill_q <= 1'b1;
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE || state == S_WB) && !flush;
    busy      = (state != S_IDLE);
    mem_req   = (state == S_MREQ);
    mem_we    = (state == S_MREQ) && store_q;
    mem_addr  = (state == S_MREQ) ? res_q : '0;
    mem_wdata = (state == S_MREQ) ? rs2_q : '0;
    wb_we     = (state == S_WB) && reg_write_q && (rd_q != '0) && !store_q;
    wb_rd     = (state == S_WB) ? rd_q : '0;
    wb_data   = (state == S_WB) ? res_q : '0;
    pend_we   = busy && reg_write_q && (rd_q != '0);
    pend_rd   = busy ? rd_q : '0;
  end

endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Bench for ex_mem_wb_stage: ALU vector table through a writeback scoreboard,
// plus hand-driven load/store/flush/reset sequences against a manual memory port.
module tb_ex_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0, in_alu_src_imm = 1'b0;
  logic [3:0]  in_alu_op = '0;
  logic        in_mem_we = 1'b0, in_mem_re = 1'b0, flush = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pend_we;
  logic [4:0]  pend_rd;
  logic        busy;

  ex_mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_alu_src_imm(in_alu_src_imm),
    .in_alu_op(in_alu_op), .in_mem_we(in_mem_we), .in_mem_re(in_mem_re),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .pend_we(pend_we), .pend_rd(pend_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } sb_t;
  sb_t sbq[$];
  sb_t mon_e;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        src_imm;
    logic [4:0]  rd;
    logic        rw;
    logic        exp_we;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // wb monitor: every write strobe must match the oldest expected writeback
  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_wb: got rd=%0d data=%h, want no write", wb_rd, wb_data);
      end else begin
        mon_e = sbq.pop_front();
        if (wb_rd !== mon_e.rd || wb_data !== mon_e.data || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          fails++;
          $display("FAIL wb_match: got rd=%0d data=%h cyc=%0d, want rd=%0d data=%h cyc=%0d",
                   wb_rd, wb_data, cyc, mon_e.rd, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  // Drive one bundle; returns just after the accept edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic [4:0] rd,
                       input logic rw, input logic re, input logic we,
                       input logic push, input logic [31:0] exp, input logic lat);
    int n;
    sb_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready !== 1'b1 && n < 20);
    if (in_ready !== 1'b1) begin
      checks++; fails++;
      $display("FAIL accept_timeout: got in_ready=%b, want 1", in_ready);
    end
    in_valid = 1'b1; in_alu_op = op; in_rs1_val = a; in_rs2_val = b; in_imm = imm;
    in_alu_src_imm = src; in_rd = rd; in_reg_write = rw; in_mem_re = re; in_mem_we = we;
    if (push) begin
      e.rd = rd; e.data = exp; e.cyc = lat ? cyc + 2 : -1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_mem_re = 1'b0; in_mem_we = 1'b0; in_reg_write = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 50);
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    chk({name, "_sb_empty"}, sbq.size(), 32'd0);
  endtask

  // Load to rd, stops at the negedge of the first MREQ cycle.
  task automatic load_to_mreq(input logic [4:0] rd);
    do_op(4'd0, 32'h40, 32'h0, 32'h4, 1'b1, rd, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{4'd0, 32'd5,        32'd0,        32'd7, 1'b1, 5'd3,  1'b1, 1'b1, 32'd12};
    vecs[1]  = '{4'd1, 32'd0,        32'd1,        32'd0, 1'b0, 5'd4,  1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[2]  = '{4'd7, 32'h80000000, 32'd4,        32'd0, 1'b0, 5'd5,  1'b1, 1'b1, 32'hF8000000};
    vecs[3]  = '{4'd8, 32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 5'd6,  1'b1, 1'b1, 32'd1};
    vecs[4]  = '{4'd9, 32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 5'd7,  1'b1, 1'b1, 32'd0};
    vecs[5]  = '{4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 5'd8,  1'b1, 1'b1, 32'hF000F000};
    vecs[6]  = '{4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 5'd9,  1'b1, 1'b1, 32'hFFF0FFF0};
    vecs[7]  = '{4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 5'd10, 1'b1, 1'b1, 32'h0FF00FF0};
    vecs[8]  = '{4'd5, 32'd1,        32'd31,       32'd0, 1'b0, 5'd11, 1'b1, 1'b1, 32'h80000000};
    vecs[9]  = '{4'd6, 32'h80000000, 32'd31,       32'd0, 1'b0, 5'd12, 1'b1, 1'b1, 32'd1};
    vecs[10] = '{4'd5, 32'd3,        32'd33,       32'd0, 1'b0, 5'd13, 1'b1, 1'b1, 32'd6};
    vecs[11] = '{4'd12, 32'd5,       32'd6,        32'd0, 1'b0, 5'd14, 1'b1, 1'b1, 32'd0};
    vecs[12] = '{4'd0, 32'hFFFFFFFF, 32'd0,        32'd2, 1'b1, 5'd15, 1'b1, 1'b1, 32'd1};
    vecs[13] = '{4'd7, 32'h7FFFFFF0, 32'd0,        32'd4, 1'b1, 5'd16, 1'b1, 1'b1, 32'h07FFFFFF};
    vecs[14] = '{4'd0, 32'd1,        32'd2,        32'd0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd0};
    vecs[15] = '{4'd0, 32'd1,        32'd2,        32'd0, 1'b0, 5'd17, 1'b0, 1'b0, 32'd0};

    // reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
    chk("rst_wb_we",    {31'd0, wb_we},    32'd0);
    chk("rst_pend_we",  {31'd0, pend_we},  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU table, issued back to back
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src_imm, vecs[i].rd,
            vecs[i].rw, 1'b0, 1'b0, vecs[i].exp_we, vecs[i].exp, 1'b1);
      if (!vecs[i].exp_we) begin
        @(negedge clk);
        @(negedge clk);
        chk("nowb_busy_in_wb", {31'd0, busy},  32'd1);
        chk("nowb_wb_we",      {31'd0, wb_we}, 32'd0);
      end
    end
    wait_idle("alu");

    // load: grant after 2 wait cycles, rvalid 3 cycles after grant
    do_op(4'd0, 32'h40, 32'h0, 32'h4, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    chk("ld_exec_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ld_req",   {31'd0, mem_req}, 32'd1);
      chk("ld_addr",  mem_addr, 32'h44);
      chk("ld_we",    {31'd0, mem_we}, 32'd0);
      chk("ld_ready", {31'd0, in_ready}, 32'd0);
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(negedge clk);
    chk("ld_wait_req", {31'd0, mem_req}, 32'd0);
    chk("ld_pend_we",  {31'd0, pend_we}, 32'd1);
    chk("ld_pend_rd",  {27'd0, pend_rd}, 32'd9);
    chk("ld_wait_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1; mem_rvalid = 1'b0; mem_rdata = '0;
    wait_idle("load");

    // store granted on first request cycle
    do_op(4'd0, 32'h10, 32'hA5, 32'h0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("st_req",   {31'd0, mem_req}, 32'd1);
    chk("st_we",    {31'd0, mem_we},  32'd1);
    chk("st_addr",  mem_addr,  32'h10);
    chk("st_wdata", mem_wdata, 32'hA5);
    mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(negedge clk);
    chk("st_req_drop", {31'd0, mem_req},  32'd0);
    chk("st_no_wb",    {31'd0, wb_we},    32'd0);
    chk("st_ready",    {31'd0, in_ready}, 32'd1);
    wait_idle("store");

    // flush in MREQ before grant
    load_to_mreq(5'd20);
    chk("fl_mreq_req", {31'd0, mem_req}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("fl_mreq_drop", {31'd0, mem_req}, 32'd0);
    chk("fl_mreq_busy", {31'd0, busy},    32'd0);
    wait_idle("fl_mreq");

    // flush in MWAIT: response drained and discarded
    load_to_mreq(5'd21);
    mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("fl_mwait_busy", {31'd0, busy}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("fl_mwait_idle", {31'd0, busy},  32'd0);
    chk("fl_mwait_nowb", {31'd0, wb_we}, 32'd0);

    // flush coincident with grant: load completes, no writeback
    load_to_mreq(5'd22);
    mem_gnt = 1'b1; flush = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fl_gnt_mwait", {31'd0, busy}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("fl_gnt_idle", {31'd0, busy}, 32'd0);
    wait_idle("fl_gnt");

    // async reset mid-request
    load_to_mreq(5'd23);
    #2 rst = 1'b0;
    #1;
    chk("rst_mreq_req",   {31'd0, mem_req},  32'd0);
    chk("rst_mreq_busy",  {31'd0, busy},     32'd0);
    chk("rst_mreq_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b1;

    // async reset in MWAIT, then a normal op
    load_to_mreq(5'd24);
    mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mwait_req",   {31'd0, mem_req},  32'd0);
    chk("rst_mwait_busy",  {31'd0, busy},     32'd0);
    chk("rst_mwait_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mwait_pend",  {31'd0, pend_we},  32'd0);
    @(negedge clk); rst = 1'b1;
    do_op(4'd0, 32'd100, 32'd23, 32'd0, 1'b0, 5'd25, 1'b1, 1'b0, 1'b0, 1'b1, 32'd123, 1'b1);
    wait_idle("post_rst");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb_stage.md
Name: ex_mem_wb_stage

Overview:
- Multi-cycle execute/memory/writeback back end for the RV32 core. It replaces the current arrangement of a combinational ALU, a single-cycle data memory and same-cycle writeback.
- Accepts one decoded ID/EX bundle per valid/ready handshake and computes the ALU result.
- Performs loads and stores over a variable-latency req/gnt/rvalid memory port, then drives one registered register-file write.
- Exposes pending-destination status to the hazard unit and supports a pipeline flush.

Parameters:
- D_WIDTH, 32, datapath and memory word width.
- RF_SIZE, 5, register index width.
- OP_SIZE, 4, alu_op width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID/EX bundle valid.
- in_ready  out  1  stage can accept a bundle.
- in_rs1_val  in  D_WIDTH  operand A.
- in_rs2_val  in  D_WIDTH  operand B / store data.
- in_imm  in  D_WIDTH  immediate.
- in_rd  in  RF_SIZE  destination register.
- in_reg_write  in  1  writes rd.
- in_alu_src_imm  in  1  B = imm when 1.
- in_alu_op  in  OP_SIZE  ALU operation.
- in_mem_we  in  1  store.
- in_mem_re  in  1  load.
- flush  in  1  kill the in-flight op.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a store.
- mem_addr  out  D_WIDTH  byte address (ALU result).
- mem_wdata  out  D_WIDTH  store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  D_WIDTH  load data.
- wb_we  out  1  register-file write strobe.
- wb_rd  out  RF_SIZE  write index.
- wb_data  out  D_WIDTH  write data.
- pend_we  out  1  in-flight op will write pend_rd.
- pend_rd  out  RF_SIZE  in-flight destination.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: rst low asynchronously forces the state to IDLE and clears all bundle/result registers.
  - All outputs go to 0 except in_ready = 1.
  - mem_req drops immediately, even mid-transaction.
- States: IDLE, EXEC, MREQ, MWAIT, WB.
- in_ready = (state==IDLE || state==WB) && !flush. A bundle is accepted on the edge where in_valid && in_ready; its fields are latched and the next state is EXEC.
- EXEC (1 cycle): the ALU result computed from the latched operands is registered into res_q.
  - in_mem_re || in_mem_we -> MREQ; otherwise -> WB.
- ALU op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is b[$clog2(D_WIDTH)-1:0].
  - 8 SLT (signed), 9 SLTU; result is 0 or 1.
  - 10–15 yield 0.
  - Arithmetic wraps modulo 2^D_WIDTH.
- MREQ:
  - Drives mem_req=1, mem_addr=res_q, mem_wdata=rs2_q, mem_we=store_q.
  - mem_req stays high, with all request fields stable, until mem_gnt is high.
  - On grant: a store goes to WB; a load goes to MWAIT.
- Both mem_re and mem_we set: treated as a load, mem_we forced 0.
- MWAIT:
  - mem_rvalid is sampled only in this state, so the earliest response is 1 cycle after the grant.
  - On rvalid, mem_rdata is captured into res_q and the state goes to WB.
- WB (1 cycle):
  - wb_we = reg_write_q && rd_q!=0; wb_rd = rd_q; wb_data = res_q.
  - All wb_* outputs are 0 outside WB.
  - Next state is EXEC if a new bundle is accepted, else IDLE.
- Latency, accept edge to WB cycle:
  - ALU op: 2 cycles; throughput is 1 op per 2 cycles.
  - Load: 2 + grant wait + rvalid wait cycles.
- pend_we = busy && reg_write_q && rd_q!=0; pend_rd = rd_q (0 when idle).
- Flush behaviour by state:
  - EXEC, or MREQ before grant: go to IDLE, no memory access, no writeback.
  - Flush in the same cycle as mem_gnt: the grant wins. The request is committed and the normal path is followed, except a granted load completes with writeback suppressed.
  - MWAIT: wait for rvalid, drop the data, go to IDLE; no writeback.
  - WB: writeback still occurs; no new bundle is accepted that cycle.
- Stores never assert wb_we, regardless of reg_write.

Test Plan:
- ADD: rs1=5, imm=7, alu_src_imm=1, rd=3 -> exactly 2 cycles after accept, wb_we=1, wb_rd=3, wb_data=12 for one cycle.
- SUB/SRA/SLT: SUB 0−1 -> 0xFFFFFFFF; SRA 0x80000000 by 4 -> 0xF8000000; SLT −1 vs 1 -> 1; SLTU −1 vs 1 -> 0.
- Load: rs1=0x40, imm=4, mem_re=1, rd=9; gnt after 2 wait cycles, rvalid 3 cycles later with 0xDEADBEEF.
  - mem_addr=0x44 held stable while ungranted.
  - wb_data=0xDEADBEEF, wb_rd=9.
  - in_ready=0 throughout.
- Store: addr 0x10, rs2=0xA5, gnt on first cycle -> one mem_req cycle with mem_we=1, wdata=0xA5; no wb_we; in_ready returns high.
- Flush:
  - Asserted in MREQ before grant -> mem_req drops next cycle, no wb.
  - Asserted in MWAIT -> rvalid data discarded, no wb.
- rd=0 and reset:
  - ADD to rd=0 -> wb_we stays 0.
  - rst pulled low during MWAIT -> mem_req=0, busy=0, in_ready=1 immediately; a subsequent op executes normally.
